// File: rtl/qsfp_mgmt_pkg.sv
// Shared types and helpers for the QSFP management controller.
package qsfp_mgmt_pkg;

   typedef enum logic [1:0] {
      ST_ABSENT,
      ST_RESET,
      ST_INIT,
      ST_READY
   } port_state_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_GAP,
      S_ON
   } sel_state_e;

   // Width needed to count 0..count-1, never narrower than one bit.
   function automatic int cntWidth(input int count);
      return (count > 1) ? $clog2(count) : 1;
   endfunction

endpackage

// File: rtl/qsfp_port_fsm.sv
// One QSFP cage: pin synchronisers, presence debouncer, bring-up FSM and
// interrupt latch.
module qsfp_port_fsm
   import qsfp_mgmt_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 10000,
   parameter int RESET_CYCLES    = 1000,
   parameter int INIT_CYCLES     = 200000
) (
   input  logic clock,
   input  logic reset,
   input  logic i_modprsl,
   input  logic i_intl,
   input  logic i_refclkReset,
   input  logic i_swReset,
   input  logic i_lpmodeReq,
   input  logic i_intClear,
   output logic o_resetl,
   output logic o_lpmode,
   output logic o_present,
   output logic o_ready,
   output logic o_intPending
);

   localparam int DEB_W   = cntWidth(DEBOUNCE_CYCLES);
   localparam int MAX_CNT = (RESET_CYCLES > INIT_CYCLES) ? RESET_CYCLES : INIT_CYCLES;
   localparam int CNT_W   = cntWidth(MAX_CNT);
   localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);

   logic             r_prsSync1;
   logic             r_prsSync2;
   logic             r_intSync1;
   logic             r_intSync2;
   logic             r_intPrev;
   logic [DEB_W-1:0] r_debCnt;
   logic             r_present;
   port_state_e      r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_resetl;
   logic             r_lpmode;
   logic             r_ready;
   logic             r_intPending;
   logic             w_intFall;

   // Two-flop synchronisers for the asynchronous pins; idle level is high.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_prsSync1 <= 1'b1;
         r_prsSync2 <= 1'b1;
         r_intSync1 <= 1'b1;
         r_intSync2 <= 1'b1;
         r_intPrev  <= 1'b1;
      end else begin
         r_prsSync1 <= i_modprsl;
         r_prsSync2 <= r_prsSync1;
         r_intSync1 <= i_intl;
         r_intSync2 <= r_intSync1;
         r_intPrev  <= r_intSync2;
      end
   end

   // Presence flips only after a full run of samples disagreeing with it.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_present <= 1'b0;
         r_debCnt  <= '0;
      end else if ((~r_prsSync2) != r_present) begin
         if (r_debCnt == DEB_LAST) begin
            r_present <= ~r_present;
            r_debCnt  <= '0;
         end else begin
            r_debCnt <= r_debCnt + DEB_W'(1);
         end
      end else begin
         r_debCnt <= '0;
      end
   end

   // Bring-up sequence ABSENT -> RESET -> INIT -> READY with registered pins.
   always_ff @(posedge clock) begin
      if (reset || !r_present) begin
         r_state  <= ST_ABSENT;
         r_cnt    <= '0;
         r_resetl <= 1'b0;
         r_lpmode <= 1'b1;
         r_ready  <= 1'b0;
      end else begin
         case (r_state)
            ST_ABSENT: begin
               if (!i_refclkReset) begin
                  r_state <= ST_RESET;
                  r_cnt   <= '0;
               end
            end
            ST_RESET: begin
               if (i_swReset) begin
                  r_cnt <= '0;
               end else if (r_cnt == RST_LAST) begin
                  r_state  <= ST_INIT;
                  r_cnt    <= '0;
                  r_resetl <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_INIT: begin
               if (i_swReset) begin
                  r_state  <= ST_RESET;
                  r_cnt    <= '0;
                  r_resetl <= 1'b0;
               end else if (r_cnt == INIT_LAST) begin
                  r_state  <= ST_READY;
                  r_cnt    <= '0;
                  r_lpmode <= i_lpmodeReq;
                  r_ready  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_READY: begin
               if (i_swReset) begin
                  r_state  <= ST_RESET;
                  r_cnt    <= '0;
                  r_resetl <= 1'b0;
                  r_lpmode <= 1'b1;
                  r_ready  <= 1'b0;
               end else begin
                  r_lpmode <= i_lpmodeReq;
               end
            end
            default: begin
               r_state  <= ST_ABSENT;
               r_cnt    <= '0;
               r_resetl <= 1'b0;
               r_lpmode <= 1'b1;
               r_ready  <= 1'b0;
            end
         endcase
      end
   end

   assign w_intFall = r_intPrev & ~r_intSync2;

   // Latch falling intl edges seen while READY; a new edge beats a clear.
   always_ff @(posedge clock) begin
      if (reset || !r_present) begin
         r_intPending <= 1'b0;
      end else if ((r_state == ST_READY) && w_intFall) begin
         r_intPending <= 1'b1;
      end else if (i_intClear) begin
         r_intPending <= 1'b0;
      end
   end

   assign o_resetl     = r_resetl;
   assign o_lpmode     = r_lpmode;
   assign o_present    = r_present;
   assign o_ready      = r_ready;
   assign o_intPending = r_intPending;

endmodule

// File: rtl/qsfp_mgmt_ctrl.sv
// Management controller for NUM_PORTS QSFP28 cages: shared refclk reset,
// per-cage bring-up, interrupt aggregation and I2C select arbitration.
module qsfp_mgmt_ctrl
   import qsfp_mgmt_pkg::*;
#(
   parameter int NUM_PORTS           = 2,
   parameter int REFCLK_RESET_CYCLES = 1000,
   parameter int DEBOUNCE_CYCLES     = 10000,
   parameter int RESET_CYCLES        = 1000,
   parameter int INIT_CYCLES         = 200000,
   parameter int SEL_GAP_CYCLES      = 100
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [NUM_PORTS-1:0]           qsfp_modprsl,
   input  logic [NUM_PORTS-1:0]           qsfp_intl,
   output logic [NUM_PORTS-1:0]           qsfp_resetl,
   output logic [NUM_PORTS-1:0]           qsfp_lpmode,
   output logic [NUM_PORTS-1:0]           qsfp_modsell,
   output logic                           qsfp_refclk_reset,
   input  logic [NUM_PORTS-1:0]           sw_reset,
   input  logic [NUM_PORTS-1:0]           lpmode_req,
   input  logic [NUM_PORTS-1:0]           int_clear,
   input  logic                           sel_valid,
   input  logic [cntWidth(NUM_PORTS)-1:0] sel_port,
   output logic                           sel_grant,
   output logic [NUM_PORTS-1:0]           port_present,
   output logic [NUM_PORTS-1:0]           port_ready,
   output logic [NUM_PORTS-1:0]           int_pending,
   output logic                           irq
);

   localparam int SEL_W = cntWidth(NUM_PORTS);
   localparam int REF_W = cntWidth(REFCLK_RESET_CYCLES);
   localparam int GAP_W = cntWidth(SEL_GAP_CYCLES);
   localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFCLK_RESET_CYCLES - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SEL_GAP_CYCLES - 1);

   logic                 r_refclkReset;
   logic [REF_W-1:0]     r_refclkCnt;
   sel_state_e           r_selState;
   logic [GAP_W-1:0]     r_gapCnt;
   logic [SEL_W-1:0]     r_selPort;
   logic [NUM_PORTS-1:0] r_modsell;
   logic                 r_selGrant;
   logic                 r_irq;
   logic [NUM_PORTS-1:0] w_ready;
   logic [NUM_PORTS-1:0] w_intPending;
   logic                 w_reqOk;

   // Hold the shared reference-clock generator in reset after every reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_refclkReset <= 1'b1;
         r_refclkCnt   <= '0;
      end else if (r_refclkReset) begin
         if (r_refclkCnt == REF_LAST) begin
            r_refclkReset <= 1'b0;
         end else begin
            r_refclkCnt <= r_refclkCnt + REF_W'(1);
         end
      end
   end

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
      qsfp_port_fsm #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_CYCLES    (RESET_CYCLES),
         .INIT_CYCLES     (INIT_CYCLES)
      ) u_port (
         .clock        (clock),
         .reset        (reset),
         .i_modprsl    (qsfp_modprsl[i]),
         .i_intl       (qsfp_intl[i]),
         .i_refclkReset(r_refclkReset),
         .i_swReset    (sw_reset[i]),
         .i_lpmodeReq  (lpmode_req[i]),
         .i_intClear   (int_clear[i]),
         .o_resetl     (qsfp_resetl[i]),
         .o_lpmode     (qsfp_lpmode[i]),
         .o_present    (port_present[i]),
         .o_ready      (w_ready[i]),
         .o_intPending (w_intPending[i])
      );
   end

   // A selection request is only acceptable for an existing port in READY.
   always_comb begin
      w_reqOk = 1'b0;
      if (sel_valid && (int'(sel_port) < NUM_PORTS)) begin
         w_reqOk = w_ready[sel_port];
      end
   end

   // I2C select arbiter: every new selection passes through an all-deselected gap.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_selState <= S_IDLE;
         r_gapCnt   <= '0;
         r_selPort  <= '0;
         r_modsell  <= '1;
         r_selGrant <= 1'b0;
      end else begin
         case (r_selState)
            S_IDLE: begin
               r_modsell  <= '1;
               r_selGrant <= 1'b0;
               if (w_reqOk) begin
                  r_selState <= S_GAP;
                  r_gapCnt   <= '0;
                  r_selPort  <= sel_port;
               end
            end
            S_GAP: begin
               if (!w_reqOk || (sel_port != r_selPort)) begin
                  r_selState <= S_IDLE;
               end else if (r_gapCnt == GAP_LAST) begin
                  r_selState <= S_ON;
                  r_modsell  <= ~(NUM_PORTS'(1) << r_selPort);
                  r_selGrant <= 1'b1;
               end else begin
                  r_gapCnt <= r_gapCnt + GAP_W'(1);
               end
            end
            S_ON: begin
               if (!sel_valid || (sel_port != r_selPort) || !w_ready[r_selPort]) begin
                  r_selState <= S_IDLE;
                  r_modsell  <= '1;
                  r_selGrant <= 1'b0;
               end
            end
            default: begin
               r_selState <= S_IDLE;
               r_modsell  <= '1;
               r_selGrant <= 1'b0;
            end
         endcase
      end
   end

   // Interrupt request trails the latched interrupts by one cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= |w_intPending;
      end
   end

   assign qsfp_refclk_reset = r_refclkReset;
   assign qsfp_modsell      = r_modsell;
   assign sel_grant         = r_selGrant;
   assign port_ready        = w_ready;
   assign int_pending       = w_intPending;
   assign irq               = r_irq;

endmodule

// File: tb/tb_qsfp_mgmt_ctrl.sv
// Self-checking bench for qsfp_mgmt_ctrl: stimulus schedules expected output
// fields at absolute cycle numbers; a negedge monitor compares and retires them.
module tb_qsfp_mgmt_ctrl;

   localparam int NUM_PORTS = 2;

   localparam int F_REFCLK  = 0;
   localparam int F_RESETL  = 1;
   localparam int F_LPMODE  = 3;
   localparam int F_MODSELL = 5;
   localparam int F_PRESENT = 7;
   localparam int F_READY   = 9;
   localparam int F_PEND    = 11;
   localparam int F_IRQ     = 13;
   localparam int F_GRANT   = 14;
   localparam int RST_VEC   = 121;

   typedef struct {
      int    when;
      string name;
      int    lsb;
      int    width;
      int    value;
   } expect_t;

   logic                 clock;
   logic                 reset;
   logic [NUM_PORTS-1:0] qsfp_modprsl;
   logic [NUM_PORTS-1:0] qsfp_intl;
   logic [NUM_PORTS-1:0] qsfp_resetl;
   logic [NUM_PORTS-1:0] qsfp_lpmode;
   logic [NUM_PORTS-1:0] qsfp_modsell;
   logic                 qsfp_refclk_reset;
   logic [NUM_PORTS-1:0] sw_reset;
   logic [NUM_PORTS-1:0] lpmode_req;
   logic [NUM_PORTS-1:0] int_clear;
   logic                 sel_valid;
   logic [0:0]           sel_port;
   logic                 sel_grant;
   logic [NUM_PORTS-1:0] port_present;
   logic [NUM_PORTS-1:0] port_ready;
   logic [NUM_PORTS-1:0] int_pending;
   logic                 irq;

   int        cyc = 0;
   int        compared = 0;
   int        mismatched = 0;
   expect_t   expQ[$];
   logic [31:0] obs;
   logic [31:0] got;
   logic [31:0] mask;

   qsfp_mgmt_ctrl #(
      .NUM_PORTS          (NUM_PORTS),
      .REFCLK_RESET_CYCLES(8),
      .DEBOUNCE_CYCLES    (4),
      .RESET_CYCLES       (5),
      .INIT_CYCLES        (10),
      .SEL_GAP_CYCLES     (3)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .qsfp_modprsl     (qsfp_modprsl),
      .qsfp_intl        (qsfp_intl),
      .qsfp_resetl      (qsfp_resetl),
      .qsfp_lpmode      (qsfp_lpmode),
      .qsfp_modsell     (qsfp_modsell),
      .qsfp_refclk_reset(qsfp_refclk_reset),
      .sw_reset         (sw_reset),
      .lpmode_req       (lpmode_req),
      .int_clear        (int_clear),
      .sel_valid        (sel_valid),
      .sel_port         (sel_port),
      .sel_grant        (sel_grant),
      .port_present     (port_present),
      .port_ready       (port_ready),
      .int_pending      (int_pending),
      .irq              (irq)
   );

   // Free-running clock.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Cycle number: count of rising edges seen so far.
   always @(posedge clock) cyc <= cyc + 1;

   // Retire every expectation scheduled for this cycle; overdue ones are failures.
   always @(negedge clock) begin
      obs = {17'd0, sel_grant, irq, int_pending, port_ready, port_present,
             qsfp_modsell, qsfp_lpmode, qsfp_resetl, qsfp_refclk_reset};
      for (int i = expQ.size() - 1; i >= 0; i--) begin
         if (expQ[i].when == cyc) begin
            mask = (32'h1 << expQ[i].width) - 32'h1;
            got  = (obs >> expQ[i].lsb) & mask;
            compared++;
            if (got != 32'(expQ[i].value)) begin
               mismatched++;
               $display("[TB] FAIL %s at cycle %0d: actual %0h required %0h",
                        expQ[i].name, cyc, got, expQ[i].value);
            end
            expQ.delete(i);
         end else if (expQ[i].when < cyc) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s: missed check scheduled at cycle %0d (now %0d)",
                     expQ[i].name, expQ[i].when, cyc);
            expQ.delete(i);
         end
      end
   end

   // Global time bound so a stuck run still terminates.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: actual timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clock);
      #2;
   endtask

   task automatic checkOutput(input string name, input int dly, input int lsb,
                              input int width, input int value);
      expQ.push_back('{when: cyc + dly, name: name, lsb: lsb, width: width, value: value});
   endtask

   // Release reset with cage 0 populated and follow it to READY.
   task automatic bringUp();
      reset = 1'b0;
      checkOutput("refclkHeld",     7,  F_REFCLK,  1, 1);
      checkOutput("refclkFall",     8,  F_REFCLK,  1, 0);
      checkOutput("presentBefore",  5,  F_PRESENT, 2, 0);
      checkOutput("presentAfter",   6,  F_PRESENT, 2, 1);
      checkOutput("resetlLow",      13, F_RESETL,  2, 0);
      checkOutput("resetlHigh",     14, F_RESETL,  2, 1);
      checkOutput("initNotReady",   23, F_READY,   2, 0);
      checkOutput("readyUp",        24, F_READY,   2, 1);
      checkOutput("readyLpmode",    24, F_LPMODE,  2, 2);
      checkOutput("port1Absent",    24, F_RESETL,  2, 1);
      waitCycles(24);
   endtask

   task automatic applyStimulus();
      reset        = 1'b1;
      qsfp_modprsl = 2'b10;
      qsfp_intl    = 2'b11;
      sw_reset     = '0;
      lpmode_req   = '0;
      int_clear    = '0;
      sel_valid    = 1'b0;
      sel_port     = '0;
      waitCycles(3);
      checkOutput("resetValues", 0, 0, 15, RST_VEC);
      waitCycles(1);

      bringUp();

      checkOutput("shortGlitchPresent", 8, F_PRESENT, 2, 1);
      checkOutput("shortGlitchReady",   8, F_READY,   2, 1);
      qsfp_modprsl = 2'b11;
      waitCycles(3);
      qsfp_modprsl = 2'b10;
      waitCycles(5);

      checkOutput("longGlitchStill",   5, F_PRESENT, 2, 1);
      checkOutput("longGlitchGone",    6, F_PRESENT, 2, 0);
      checkOutput("longGlitchReady1",  6, F_READY,   2, 1);
      checkOutput("longGlitchReady0",  7, F_READY,   2, 0);
      checkOutput("longGlitchResetl",  7, F_RESETL,  2, 0);
      qsfp_modprsl = 2'b11;
      waitCycles(7);
      qsfp_modprsl = 2'b10;
      checkOutput("reinsertNotReady", 21, F_READY, 2, 0);
      checkOutput("reinsertReady",    22, F_READY, 2, 1);
      waitCycles(22);

      checkOutput("intSyncDelay", 2, F_PEND, 2, 0);
      checkOutput("intLatched",   3, F_PEND, 2, 1);
      checkOutput("irqLag",       3, F_IRQ,  1, 0);
      checkOutput("irqSet",       4, F_IRQ,  1, 1);
      qsfp_intl = 2'b10;
      waitCycles(4);
      qsfp_intl = 2'b11;
      checkOutput("clearBefore", 0, F_PEND, 2, 1);
      checkOutput("clearAfter",  1, F_PEND, 2, 0);
      checkOutput("irqHeld",     1, F_IRQ,  1, 1);
      checkOutput("irqDrop",     2, F_IRQ,  1, 0);
      int_clear = 2'b01;
      waitCycles(1);
      int_clear = 2'b00;
      waitCycles(3);

      checkOutput("setWinsPre",  2, F_PEND, 2, 0);
      checkOutput("setWins",     3, F_PEND, 2, 1);
      checkOutput("setWinsHold", 4, F_PEND, 2, 1);
      checkOutput("setWinsIrq0", 3, F_IRQ,  1, 0);
      checkOutput("setWinsIrq1", 5, F_IRQ,  1, 1);
      qsfp_intl = 2'b10;
      waitCycles(2);
      int_clear = 2'b01;
      waitCycles(1);
      int_clear = 2'b00;
      waitCycles(3);
      checkOutput("finalClear", 1, F_PEND, 2, 0);
      int_clear = 2'b01;
      qsfp_intl = 2'b11;
      waitCycles(1);
      int_clear = 2'b00;
      waitCycles(2);

      checkOutput("lpmodeLow",  0, F_LPMODE, 2, 2);
      checkOutput("lpmodeReq",  1, F_LPMODE, 2, 3);
      lpmode_req = 2'b01;
      waitCycles(1);
      lpmode_req = 2'b00;
      checkOutput("lpmodeBack", 1, F_LPMODE, 2, 2);
      waitCycles(1);

      checkOutput("swResetPre",      0,  F_RESETL, 2, 1);
      checkOutput("swResetLow",      1,  F_RESETL, 2, 0);
      checkOutput("swResetLowEnd",   5,  F_RESETL, 2, 0);
      checkOutput("swResetRelease",  6,  F_RESETL, 2, 1);
      checkOutput("swLpmodeForced",  1,  F_LPMODE, 2, 3);
      checkOutput("swLpmodeInit",    15, F_LPMODE, 2, 3);
      checkOutput("swLpmodeReady",   16, F_LPMODE, 2, 2);
      checkOutput("swNotReady",      15, F_READY,  2, 0);
      checkOutput("swReady",         16, F_READY,  2, 1);
      sw_reset = 2'b01;
      waitCycles(1);
      sw_reset = 2'b00;
      waitCycles(15);

      checkOutput("gapModsell1", 1, F_MODSELL, 2, 3);
      checkOutput("gapModsell3", 3, F_MODSELL, 2, 3);
      checkOutput("gapNoGrant",  3, F_GRANT,   1, 0);
      checkOutput("selModsell",  4, F_MODSELL, 2, 2);
      checkOutput("selGrant",    4, F_GRANT,   1, 1);
      sel_valid = 1'b1;
      sel_port  = 1'b0;
      waitCycles(6);
      checkOutput("switchDeselect", 1, F_MODSELL, 2, 3);
      checkOutput("switchNoGrant",  1, F_GRANT,   1, 0);
      checkOutput("notReadyGrant",  6, F_GRANT,   1, 0);
      checkOutput("notReadyModsel", 6, F_MODSELL, 2, 3);
      sel_port = 1'b1;
      waitCycles(6);
      checkOutput("regrant", 4, F_GRANT, 1, 1);
      sel_port = 1'b0;
      waitCycles(5);
      checkOutput("leaveReadyHold", 1, F_GRANT,   1, 1);
      checkOutput("leaveReadyDrop", 2, F_GRANT,   1, 0);
      checkOutput("leaveReadyMods", 2, F_MODSELL, 2, 3);
      sw_reset = 2'b01;
      waitCycles(1);
      sw_reset = 2'b00;
      waitCycles(7);

      checkOutput("inInitResetl", 0, F_RESETL, 2, 1);
      checkOutput("inInitReady",  0, F_READY,  2, 0);
      checkOutput("midInitReset", 1, 0, 15, RST_VEC);
      reset = 1'b1;
      waitCycles(3);

      bringUp();
      checkOutput("onGapNoGrant", 3, F_GRANT,   1, 0);
      checkOutput("onGrant",      4, F_GRANT,   1, 1);
      checkOutput("onModsell",    4, F_MODSELL, 2, 2);
      waitCycles(5);
      checkOutput("midOnReset", 1, 0, 15, RST_VEC);
      reset = 1'b1;
      waitCycles(2);
      reset = 1'b0;
      waitCycles(3);
   endtask

   // Run the directed sequence, flush leftovers, report.
   initial begin
      applyStimulus();
      waitCycles(2);
      while (expQ.size() != 0) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL %s: actual unchecked required check at cycle %0d",
                  expQ[0].name, expQ[0].when);
         expQ.delete(0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
